// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg
// Shared definitions for the two-requester round-robin arbiter that owns the
// select line of a mux2_to_1 datapath.
//   HOLD_W           : width of the tenure hold counter
//   MAX_HOLD_DEFAULT : default tenure limit under contention (legal 1..15)
//   state_t          : arbiter state; one-hot over {gnt1, gnt0}, zero = idle
package mux2_arbiter_pkg;

  localparam int HOLD_W           = 4;
  localparam int MAX_HOLD_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

endpackage

// File: rtl/mux2_arbiter_hold_counter.sv
// hold_counter
// Counts how many cycles the current owner has held the grant while the
// other requester waited. Saturates at MAX_HOLD-1 so it never leaves range.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (count -> 0)
//   clr     : synchronous clear, asserted on every grant change
//   en      : advance the count (owner is being contested)
//   expired : count has reached MAX_HOLD-1
module hold_counter
  import mux2_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] count_r;

  // Tenure counter: clear wins over enable; saturate at LIMIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {HOLD_W{1'b0}};
    end else if (clr) begin
      count_r <= {HOLD_W{1'b0}};
    end else if (en && (count_r != LIMIT)) begin
      count_r <= count_r + HOLD_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter
// Round-robin arbiter sharing one mux2_to_1 between two requesters. It drives
// the mux select S, grants one requester at a time and forces a rotation after
// MAX_HOLD contested cycles so neither requester can starve the other.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   req0    : requester 0 wants the mux (I0 path)
//   req1    : requester 1 wants the mux (I1 path)
//   gnt0    : requester 0 owns the mux (registered)
//   gnt1    : requester 1 owns the mux (registered)
//   S       : mux select, 0 = I0, 1 = I1 (registered, held while idle)
//   busy    : gnt0 | gnt1 (registered)
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic S,
  output logic busy
);

  state_t state_r;
  state_t next_state_s;
  logic   last_r;
  logic   sel_r;
  logic   gnt0_r;
  logic   gnt1_r;
  logic   busy_r;
  logic   expired_s;
  logic   clr_s;
  logic   en_s;

  hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (clr_s),
    .en      (en_s),
    .expired (expired_s)
  );

  // Next-state arbitration and hold-counter control.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        // On a tie, serve the requester that was not served last.
        if (req0 && req1) begin
          next_state_s = last_r ? ST_OWN0 : ST_OWN1;
        end else if (req0) begin
          next_state_s = ST_OWN0;
        end else if (req1) begin
          next_state_s = ST_OWN1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (!req0) begin
          next_state_s = req1 ? ST_OWN1 : ST_IDLE;
        end else if (req1 && expired_s) begin
          next_state_s = ST_OWN1;
        end else begin
          next_state_s = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          next_state_s = req0 ? ST_OWN0 : ST_IDLE;
        end else if (req0 && expired_s) begin
          next_state_s = ST_OWN0;
        end else begin
          next_state_s = ST_OWN1;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase

    // Count only while the owner is contested; restart on any grant change.
    en_s  = ((state_r == ST_OWN0) && req1) || ((state_r == ST_OWN1) && req0);
    clr_s = (next_state_s != state_r);
  end

  // FSM state, last-served pointer and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      busy_r  <= 1'b0;
      sel_r   <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      gnt0_r  <= (next_state_s == ST_OWN0);
      gnt1_r  <= (next_state_s == ST_OWN1);
      busy_r  <= (next_state_s != ST_IDLE);
      // Select and pointer follow the owner; both hold while idle so the
      // mux output does not move between tenures.
      case (next_state_s)
        ST_OWN0: begin
          sel_r  <= 1'b0;
          last_r <= 1'b0;
        end
        ST_OWN1: begin
          sel_r  <= 1'b1;
          last_r <= 1'b1;
        end
        default: begin
          sel_r  <= sel_r;
          last_r <= last_r;
        end
      endcase
    end
  end

  assign gnt0 = gnt0_r;
  assign gnt1 = gnt1_r;
  assign S    = sel_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter
// Scoreboard bench: a behavioural model predicts {gnt0, gnt1, S, busy} after
// every rising edge and queues it; a monitor compares on the falling edge.
module tb_mux2_arbiter;

  localparam int MAX_HOLD = 4;

  logic clock = 1'b0;
  logic reset_n;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic S;
  logic busy;

  // Stand-in for the mux2_to_1 datapath with I0 = 0, I1 = 1.
  logic mux_i0;
  logic mux_i1;
  logic mux_out;
  assign mux_i0  = 1'b0;
  assign mux_i1  = 1'b1;
  assign mux_out = S ? mux_i1 : mux_i0;

  int tests = 0;
  int fails = 0;
  logic contend = 1'b0;

  logic [3:0] exp_q[$];

  always #5 clock = ~clock;

  mux2_arbiter #(
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .S       (S),
    .busy    (busy)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: owner -1 = nobody, 0 or 1 = that requester.
  initial begin : model
    int   owner;
    int   last;
    int   waited;
    int   nxt;
    logic sel;
    logic mine;
    logic other;
    owner  = -1;
    last   = 1;
    waited = 0;
    sel    = 1'b0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (reset_n !== 1'b1) begin
        owner  = -1;
        last   = 1;
        waited = 0;
        sel    = 1'b0;
        exp_q.delete();
      end else begin
        nxt = owner;
        if (owner < 0) begin
          if (req0 && req1) nxt = (last == 1) ? 0 : 1;
          else if (req0)    nxt = 0;
          else if (req1)    nxt = 1;
        end else begin
          mine  = (owner == 0) ? req0 : req1;
          other = (owner == 0) ? req1 : req0;
          if (!mine) begin
            nxt = other ? 1 - owner : -1;
          end else if (other) begin
            if (waited == MAX_HOLD - 1) nxt = 1 - owner;
            else waited++;
          end
        end
        if (nxt != owner) begin
          waited = 0;
          if (nxt >= 0) begin
            last = nxt;
            sel  = (nxt == 1);
          end
        end
        owner = nxt;
        exp_q.push_back({owner == 0, owner == 1, sel, owner >= 0});
      end
    end
  end

  // Monitor: compare one prediction per cycle, away from the active edge.
  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs{gnt0,gnt1,S,busy}", {gnt0, gnt1, S, busy}, e);
        check("grant_mutex", {3'b000, gnt0 & gnt1}, 4'b0000);
        if (contend) check("datapath_out", {3'b000, mux_out}, {3'b000, gnt1});
      end
    end
  end

  task automatic drive(input logic a, input logic b, input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
      req0 = a;
      req1 = b;
    end
  endtask

  initial begin : stimulus
    reset_n = 1'b0;
    req0    = 1'b0;
    req1    = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_state", {gnt0, gnt1, S, busy}, 4'b0000);
    #1 reset_n = 1'b1;

    // Single uncontested requester, then release: S must stay at 1.
    drive(1'b0, 1'b1, 20);
    drive(1'b0, 1'b0, 3);

    // Continuous contention: 4-cycle tenures alternating, datapath tracks gnt1.
    drive(1'b1, 1'b1, 1);
    contend = 1'b1;
    drive(1'b1, 1'b1, 16);
    contend = 1'b0;
    drive(1'b0, 1'b0, 2);

    // Direct handoff OWN0 -> OWN1 with no idle cycle.
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b1, 3);
    drive(1'b0, 1'b0, 2);

    // Round-robin ties from idle after serving each side.
    drive(1'b0, 1'b1, 2);
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 2);
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b0, 2);

    // Random request patterns held for random lengths.
    repeat (150) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 7)));
    end

    // Asynchronous reset mid-tenure while gnt1 is held.
    drive(1'b0, 1'b1, 3);
    @(negedge clock);
    #2;
    req0    = 1'b1;
    req1    = 1'b1;
    reset_n = 1'b0;
    #1;
    check("async_reset", {gnt0, gnt1, S, busy}, 4'b0000);
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("reset_release_tie", {gnt0, gnt1, S, busy}, 4'b1001);
    drive(1'b1, 1'b1, 6);
    drive(1'b0, 1'b0, 3);

    repeat (3) @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
